// File: rtl/iter_shifter.sv
// iter_shifter: multi-cycle shift unit (SLL/SRL/SRA/ROTR) shifting at most STEP bits per cycle,
// with a start/busy/done handshake for the multicycle CPU control FSM.
module iter_shifter #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH),
    parameter int STEP    = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   data_in,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   result
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    localparam logic [SHAMT_W:0] STEP_W = (SHAMT_W + 1)'(STEP);
    state_t                r_state, w_next;
    logic [WIDTH-1:0]      r_work, r_result, w_shifted, w_sra;
    logic [SHAMT_W-1:0]    r_rem, w_rem_nx;
    logic [1:0]            r_op;
    logic [SHAMT_W:0]      w_k;
    logic [2*WIDTH-1:0]    w_rot;
    logic                  w_accept;

    assign w_accept = start && (r_state != SHIFT);
    assign w_k      = ({1'b0, r_rem} < STEP_W) ? {1'b0, r_rem} : STEP_W;
    assign w_rem_nx = r_rem - w_k[SHAMT_W-1:0];
    // Rotation: shifting a doubled word right brings LSB bits back in at the MSB
    assign w_rot    = {r_work, r_work} >> w_k;
    // Kept apart so the arithmetic shift is not forced unsigned by a mixed ternary
    assign w_sra    = $signed(r_work) >>> w_k;

    always_comb begin
        w_shifted = (r_op == 2'b00) ? r_work << w_k :
                    (r_op == 2'b01) ? r_work >> w_k :
                    (r_op == 2'b10) ? w_sra : w_rot[WIDTH-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = (r_state == SHIFT) ? ((w_rem_nx == '0) ? DONE : SHIFT) :
                 w_accept ? ((shamt == '0) ? DONE : SHIFT) : IDLE;
    end

    always_comb begin
        busy = (r_state == SHIFT);
        done = (r_state == DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_work   <= '0;
            r_rem    <= '0;
            r_op     <= '0;
            r_result <= '0;
        end else if (w_accept) begin
            r_work <= data_in;
            r_rem  <= shamt;
            r_op   <= op;
            if (shamt == '0) r_result <= data_in;
        end else if (r_state == SHIFT) begin
            r_work <= w_shifted;
            r_rem  <= w_rem_nx;
            if (w_rem_nx == '0) r_result <= w_shifted;
        end
    end

    assign result = r_result;
endmodule
